core_sequencer: RTL

- Multi-cycle core controller. Initiator side of the stage enable/completed handshake.
- Walks one instruction at a time through FETCH, DECODE, EXEC, MEM and WB.
- Issues a one-cycle enable pulse to each stage and waits for that stage's completed pulse.
- Owns the architectural PC and consumes the branch outcome (is_jump_chosen, jump_dest) from the execute stage.

---
 rtl/core_sequencer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/core_sequencer.sv
// Multi-cycle core sequencer. Walks one instruction at a time through
// FETCH, DECODE, EXEC, MEM and WB, firing a one-cycle enable into each stage
// and waiting for that stage's completed pulse. Owns the architectural PC,
// the retired-instruction counter and a per-stage timeout.
//
// Handshake (initiator side): *_enabled is high only in the first cycle of a
// stage state (the entry cycle). The matching *_completed is honoured in any
// later cycle of that state and is ignored in the entry cycle, ignored for
// non-current stages, and ignored outside the stage states.
module core_sequencer #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             run,
  input  logic             halt_req,
  output logic             fetch_enabled,
  input  logic             fetch_completed,
  output logic [31:0]      fetch_pc,
  output logic             decode_enabled,
  input  logic             decode_completed,
  output logic             exec_enabled,
  input  logic             exec_completed,
  input  logic             exec_is_jump_chosen,
  input  logic [31:0]      exec_jump_dest,
  output logic             mem_enabled,
  input  logic             mem_completed,
  output logic             wb_enabled,
  input  logic             wb_completed,
  output logic [31:0]      pc,
  output logic             busy,
  output logic             halted,
  output logic             error,
  output logic [CNT_W-1:0] retired_count,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  // Timer value seen in the last non-entry cycle still allowed to complete.
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic        halt_latch;
  logic        jump_taken;
  logic [31:0] jump_target;
  logic [31:0] timer;

  logic in_stage;
  logic cur_en;
  logic cur_done_in;
  logic stage_done;
  logic stage_timeout;
  logic halt_now;
  logic misaligned;

  // Pick the enable/completed pair belonging to the current stage.
  always_comb begin
    in_stage    = 1'b1;
    cur_en      = 1'b0;
    cur_done_in = 1'b0;
    case (state)
      S_FETCH:  begin cur_en = fetch_enabled;  cur_done_in = fetch_completed;  end
      S_DECODE: begin cur_en = decode_enabled; cur_done_in = decode_completed; end
      S_EXEC:   begin cur_en = exec_enabled;   cur_done_in = exec_completed;   end
      S_MEM:    begin cur_en = mem_enabled;    cur_done_in = mem_completed;    end
      S_WB:     begin cur_en = wb_enabled;     cur_done_in = wb_completed;     end
      default:  in_stage = 1'b0;
    endcase
  end

  // Completion wins over a timeout landing in the same cycle.
  assign stage_done    = in_stage && !cur_en && cur_done_in;
  assign stage_timeout = (TIMEOUT_CYCLES != 0) && in_stage && !cur_en &&
                         !cur_done_in && (timer == TIMEOUT_LAST);
  // A halt request arriving in the final WB cycle still counts.
  assign halt_now      = halt_latch || halt_req;
  assign misaligned    = exec_is_jump_chosen && (exec_jump_dest[1:0] != 2'b00);

  // Status flags are straight decodes of the state register.
  assign state_o  = state;
  assign busy     = in_stage;
  assign halted   = (state == S_HALT);
  assign error    = (state == S_ERROR);
  assign fetch_pc = pc;

  // Sequencer FSM: state, stage enables, PC, counters and latches.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state          <= S_IDLE;
      pc             <= RESET_PC;
      retired_count  <= '0;
      timer          <= '0;
      halt_latch     <= 1'b0;
      jump_taken     <= 1'b0;
      jump_target    <= '0;
      fetch_enabled  <= 1'b0;
      decode_enabled <= 1'b0;
      exec_enabled   <= 1'b0;
      mem_enabled    <= 1'b0;
      wb_enabled     <= 1'b0;
    end else begin
      fetch_enabled  <= 1'b0;
      decode_enabled <= 1'b0;
      exec_enabled   <= 1'b0;
      mem_enabled    <= 1'b0;
      wb_enabled     <= 1'b0;
      if (in_stage && halt_req) halt_latch <= 1'b1;

      case (state)
        S_IDLE: begin
          if (run) begin
            state         <= S_FETCH;
            fetch_enabled <= 1'b1;
            timer         <= '0;
          end
        end
        S_HALT: begin
          if (run) begin
            state         <= S_FETCH;
            fetch_enabled <= 1'b1;
            timer         <= '0;
            halt_latch    <= 1'b0;
          end
        end
        S_ERROR: begin
          state <= S_ERROR;
        end
        default: begin
          if (stage_done) begin
            timer <= '0;
            case (state)
              S_FETCH: begin
                state          <= S_DECODE;
                decode_enabled <= 1'b1;
              end
              S_DECODE: begin
                state        <= S_EXEC;
                exec_enabled <= 1'b1;
              end
              S_EXEC: begin
                jump_taken  <= exec_is_jump_chosen;
                jump_target <= exec_jump_dest;
                if (misaligned) begin
                  state <= S_ERROR;
                end else begin
                  state       <= S_MEM;
                  mem_enabled <= 1'b1;
                end
              end
              S_MEM: begin
                state      <= S_WB;
                wb_enabled <= 1'b1;
              end
              default: begin
                retired_count <= retired_count + CNT_W'(1);
                pc            <= jump_taken ? jump_target : pc + 32'd4;
                if (halt_now) begin
                  state <= S_HALT;
                end else begin
                  state         <= S_FETCH;
                  fetch_enabled <= 1'b1;
                end
              end
            endcase
          end else if (stage_timeout) begin
            state <= S_ERROR;
          end else if (!cur_en) begin
            timer <= timer + 32'd1;
          end
        end
      endcase
    end
  end

endmodule
